// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier and restoring radix-2 divider
// on operand magnitudes, with valid/ready handshakes on both sides and flush support.
module mdu_iter #(
    parameter int XLEN     = 64,
    parameter int MUL_STEP = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      op_i,
    input  logic            is_word_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
    localparam logic [XLEN-1:0] WORD_MIN  = {{(XLEN-32){1'b0}}, 32'h8000_0000};
    localparam logic [XLEN-1:0] XLEN_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d, lim_q, lim_d;
    logic [2:0]        op_q, op_d;
    logic              isWord_q, isWord_d;
    logic              negRes_q, negRes_d;
    logic              negRem_q, negRem_d;
    logic [2*XLEN-1:0] opA_q, opA_d;
    logic [XLEN-1:0]   opB_q, opB_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   resInt_q, resInt_d;
    logic              outValid_q, outValid_d;
    logic [XLEN-1:0]   result_q, result_d;

    function automatic logic [XLEN-1:0] fixWord(input logic w, input logic [XLEN-1:0] r);
        return w ? {{(XLEN-32){r[31]}}, r[31:0]} : r;
    endfunction

    logic [XLEN-1:0] wMask, srcA, srcB, magA, magB, specialRes;
    logic            signA, signB, isSpecial;
    logic [CW-1:0]   limMul, limDiv;

    // Operands are reduced to W-bit magnitudes up front; the sign is re-applied on the last step.
    always_comb begin
        wMask      = is_word_i ? WORD_MASK : '1;
        srcA       = src1_i & wMask;
        srcB       = src2_i & wMask;
        signA      = (op_i != 3'd3 && op_i != 3'd5 && op_i != 3'd7) &&
                     (is_word_i ? src1_i[31] : src1_i[XLEN-1]);
        signB      = (op_i == 3'd0 || op_i == 3'd1 || op_i == 3'd4 || op_i == 3'd6) &&
                     (is_word_i ? src2_i[31] : src2_i[XLEN-1]);
        magA       = signA ? ((-srcA) & wMask) : srcA;
        magB       = signB ? ((-srcB) & wMask) : srcB;
        isSpecial  = 1'b0;
        specialRes = '0;
        if (srcB == '0) begin
            isSpecial  = 1'b1;
            specialRes = fixWord(is_word_i, op_i[1] ? srcA : wMask);
        end else if (!op_i[0] && srcA == (is_word_i ? WORD_MIN : XLEN_MIN) && srcB == wMask) begin
            isSpecial  = 1'b1;
            specialRes = fixWord(is_word_i, op_i[1] ? '0 : srcA);
        end
        limMul = is_word_i ? CW'(32 / MUL_STEP) : CW'(XLEN / MUL_STEP);
        limDiv = is_word_i ? CW'(32) : CW'(XLEN);
    end

    logic [2*XLEN-1:0] mulAcc, mulFinal;
    logic [XLEN:0]     remShift, remDiff;
    logic              qBit, lastIter;
    logic [XLEN-1:0]   remNext, quoNext, quoFinal, remFinal, mulRes, divRes;
    logic [CW-1:0]     cntInc;

    always_comb begin
        mulAcc = acc_q;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (opB_q[j]) mulAcc = mulAcc + (opA_q << j);
        end
        mulFinal = negRes_q ? -mulAcc : mulAcc;
        mulRes   = fixWord(isWord_q, (!isWord_q && op_q != 3'd0) ? mulFinal[2*XLEN-1:XLEN]
                                                                   : mulFinal[XLEN-1:0]);
        // The dividend shifts out of opB from the top while quotient bits enter at the bottom.
        remShift = {acc_q[XLEN-1:0], opB_q[XLEN-1]};
        remDiff  = remShift - {1'b0, opA_q[XLEN-1:0]};
        qBit     = !remDiff[XLEN];
        remNext  = qBit ? remDiff[XLEN-1:0] : remShift[XLEN-1:0];
        quoNext  = {opB_q[XLEN-2:0], qBit};
        quoFinal = negRes_q ? -quoNext : quoNext;
        remFinal = negRem_q ? -remNext : remNext;
        divRes   = fixWord(isWord_q, op_q[1] ? remFinal : quoFinal);
        cntInc   = cnt_q + CW'(1);
        lastIter = (cntInc == lim_q);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lim_d      = lim_q;
        op_d       = op_q;
        isWord_d   = isWord_q;
        negRes_d   = negRes_q;
        negRem_d   = negRem_q;
        opA_d      = opA_q;
        opB_d      = opB_q;
        acc_d      = acc_q;
        resInt_d   = resInt_q;
        outValid_d = outValid_q;
        result_d   = result_q;
        if (flush_i) begin
            state_d    = IDLE;
            outValid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid_i) begin
                    op_d     = op_i;
                    isWord_d = is_word_i;
                    cnt_d    = '0;
                    acc_d    = '0;
                    negRes_d = signA ^ signB;
                    negRem_d = signA;
                    if (op_i[2] && isSpecial) begin
                        resInt_d = specialRes;
                        state_d  = DONE;
                    end else if (op_i[2]) begin
                        opA_d   = {{XLEN{1'b0}}, magB};
                        opB_d   = is_word_i ? (magA << (XLEN - 32)) : magA;
                        lim_d   = limDiv;
                        state_d = DIV;
                    end else begin
                        opA_d   = {{XLEN{1'b0}}, magA};
                        opB_d   = magB;
                        lim_d   = limMul;
                        state_d = MUL;
                    end
                end
                MUL: begin
                    acc_d = mulAcc;
                    opA_d = opA_q << MUL_STEP;
                    opB_d = opB_q >> MUL_STEP;
                    cnt_d = cntInc;
                    if (lastIter) begin
                        resInt_d = mulRes;
                        state_d  = DONE;
                    end
                end
                DIV: begin
                    acc_d = {{XLEN{1'b0}}, remNext};
                    opB_d = quoNext;
                    cnt_d = cntInc;
                    if (lastIter) begin
                        resInt_d = divRes;
                        state_d  = DONE;
                    end
                end
                // First DONE cycle publishes the result; it is then held until taken.
                DONE: if (!outValid_q) begin
                    outValid_d = 1'b1;
                    result_d   = resInt_q;
                end else if (out_ready_i) begin
                    outValid_d = 1'b0;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lim_q      <= '0;
            op_q       <= '0;
            isWord_q   <= 1'b0;
            negRes_q   <= 1'b0;
            negRem_q   <= 1'b0;
            opA_q      <= '0;
            opB_q      <= '0;
            acc_q      <= '0;
            resInt_q   <= '0;
            outValid_q <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lim_q      <= lim_d;
            op_q       <= op_d;
            isWord_q   <= isWord_d;
            negRes_q   <= negRes_d;
            negRem_q   <= negRem_d;
            opA_q      <= opA_d;
            opB_q      <= opB_d;
            acc_q      <= acc_d;
            resInt_q   <= resInt_d;
            outValid_q <= outValid_d;
            result_q   <= result_d;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = outValid_q;
    assign result_o    = result_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter: two instances (MUL_STEP=1 and 4) share one request stream and are
// checked against an arithmetic RV64M reference model, plus hold, flush and reset scenarios.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inValid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        isWord = 1'b0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic        flush = 1'b0;
    logic        outReady = 1'b1;
    logic        inReady1, outValid1, inReady4, outValid4;
    logic [63:0] result1, result4;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    mdu_iter #(.XLEN(64), .MUL_STEP(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReady1), .op_i(op),
        .is_word_i(isWord), .src1_i(src1), .src2_i(src2), .flush_i(flush),
        .out_valid_o(outValid1), .out_ready_i(outReady), .result_o(result1));

    mdu_iter #(.XLEN(64), .MUL_STEP(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(inValid), .in_ready_o(inReady4), .op_i(op),
        .is_word_i(isWord), .src1_i(src1), .src2_i(src2), .flush_i(flush),
        .out_valid_o(outValid4), .out_ready_i(outReady), .result_o(result4));

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference result straight from the RV64M definitions using native SV arithmetic.
    function automatic logic [63:0] refModel(input logic [2:0] f, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0]  sa, sb, q64;
        logic signed [31:0]  sa32, sb32, q32;
        logic [31:0]         ua32, ub32, r32;
        logic signed [127:0] sp;
        logic [127:0]        up;
        logic [63:0]         r;
        sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
        r = '0; r32 = '0;
        if (w) begin
            case (f)
                3'd4: if (ub32 == 0) r32 = '1;
                      else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = ua32;
                      else begin q32 = sa32 / sb32; r32 = q32; end
                3'd5: if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32;
                3'd6: if (ub32 == 0) r32 = ua32;
                      else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = '0;
                      else begin q32 = sa32 % sb32; r32 = q32; end
                3'd7: if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32;
                default: r32 = ua32 * ub32;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (f)
                3'd0: r = a * b;
                3'd1: begin sp = sa * sb; r = sp[127:64]; end
                3'd2: begin sp = sa * $signed({1'b0, b}); r = sp[127:64]; end
                3'd3: begin up = a * b; r = up[127:64]; end
                3'd4: if (b == 0) r = '1;
                      else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                      else begin q64 = sa / sb; r = q64; end
                3'd5: if (b == 0) r = '1; else r = a / b;
                3'd6: if (b == 0) r = a;
                      else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                      else begin q64 = sa % sb; r = q64; end
                default: if (b == 0) r = a; else r = a % b;
            endcase
        end
        return r;
    endfunction

    function automatic int expLatency(input logic [2:0] f, input logic w,
                                      input logic [63:0] a, input logic [63:0] b, input int step);
        int width;
        logic [63:0] am, bm;
        width = w ? 32 : 64;
        am = w ? {32'b0, a[31:0]} : a;
        bm = w ? {32'b0, b[31:0]} : b;
        if (f[2]) begin
            if (bm == 0) return 1;
            if (!f[0] && am == (w ? 64'h8000_0000 : 64'h8000_0000_0000_0000) &&
                bm == (w ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF)) return 1;
            return width + 1;
        end
        return width / step + 1;
    endfunction

    function automatic logic [63:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h0000_0000_8000_0000;
            4: return 64'($urandom_range(0, 1000));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic driveReq(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
        inValid = 1'b1; op = f; isWord = w; src1 = a; src2 = b;
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] f, input logic w,
                                 input logic [63:0] a, input logic [63:0] b, input logic [63:0] expected);
        int lat1, lat4;
        logic [63:0] res1, res4;
        lat1 = -1; lat4 = -1; res1 = '0; res4 = '0;
        @(negedge clk);
        driveReq(f, w, a, b);
        @(posedge clk); #1;
        inValid = 1'b0; op = 3'($urandom); isWord = 1'($urandom); src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        for (int k = 1; k <= 200 && (lat1 < 0 || lat4 < 0); k++) begin
            @(posedge clk); #1;
            if (lat1 < 0 && outValid1) begin lat1 = k; res1 = result1; end
            if (lat4 < 0 && outValid4) begin lat4 = k; res4 = result4; end
        end
        checkOutput({tag, "/lat1"}, 64'(lat1), 64'(expLatency(f, w, a, b, 1)));
        checkOutput({tag, "/lat4"}, 64'(lat4), 64'(expLatency(f, w, a, b, 4)));
        checkOutput({tag, "/res1"}, res1, expected);
        checkOutput({tag, "/res4"}, res4, expected);
        repeat (2) @(posedge clk);
        #1 checkOutput({tag, "/idle"}, {62'b0, inReady1, inReady4}, 64'd3);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic sawValid;
        logic [2:0] rop;
        logic rw;
        logic [63:0] ra, rb;
        int waited;

        #2 rst = 1'b1;
        #1;
        checkOutput("reset/flags", {60'b0, outValid1, inReady1, outValid4, inReady4}, 64'b0101);
        checkOutput("reset/result1", result1, 64'd0);
        checkOutput("reset/result4", result4, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        applyStimulus("mul", 3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB);
        applyStimulus("mulhu", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus("div", 3'd4, 1'b0, -64'sd7, 64'd2, -64'sd3);
        applyStimulus("rem", 3'd6, 1'b0, -64'sd7, 64'd2, -64'sd1);
        applyStimulus("divuZero", 3'd5, 1'b0, 64'd12345, 64'd0, '1);
        applyStimulus("remOvf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0);
        applyStimulus("divwOvf", 3'd4, 1'b1, 64'h1_8000_0000, '1, 64'hFFFF_FFFF_8000_0000);
        applyStimulus("remuw", 3'd7, 1'b1, 64'hFFFF_FFFF, 64'd10, 64'd5);

        // Result must stay frozen while the consumer stalls.
        outReady = 1'b0;
        @(negedge clk);
        driveReq(3'd4, 1'b0, -64'sd7, 64'd2);
        @(posedge clk); #1;
        inValid = 1'b0;
        waited = 0;
        while (!outValid1 && waited < 200) begin @(posedge clk); #1; waited++; end
        checkOutput("hold/lat", 64'(waited), 64'd65);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold/flags", {60'b0, outValid1, inReady1, outValid4, inReady4}, 64'b1010);
            checkOutput("hold/result1", result1, -64'sd3);
            checkOutput("hold/result4", result4, -64'sd3);
            @(posedge clk); #1;
        end
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("hold/release", {60'b0, outValid1, inReady1, outValid4, inReady4}, 64'b0101);

        // A request coinciding with flush in IDLE is dropped.
        @(negedge clk);
        driveReq(3'd5, 1'b0, 64'd123, 64'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; inValid = 1'b0;
        sawValid = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (outValid1 || outValid4) sawValid = 1'b1; end
        checkOutput("flushIdle/noValid", {63'b0, sawValid}, 64'd0);
        checkOutput("flushIdle/ready", {62'b0, inReady1, inReady4}, 64'd3);

        // Flush during the tenth divide iteration.
        @(negedge clk);
        driveReq(3'd5, 1'b0, 64'd1000, 64'd7);
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        driveReq(3'd0, 1'b0, 64'd3, 64'd4);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; inValid = 1'b0;
        checkOutput("flushDiv/flags", {60'b0, outValid1, inReady1, outValid4, inReady4}, 64'b0101);
        sawValid = 1'b0;
        repeat (80) begin @(posedge clk); #1; if (outValid1 || outValid4) sawValid = 1'b1; end
        checkOutput("flushDiv/noValid", {63'b0, sawValid}, 64'd0);
        applyStimulus("afterFlush", 3'd4, 1'b0, 64'd100, 64'd7, 64'd14);

        // Reset in the middle of a multiply.
        @(negedge clk);
        driveReq(3'd1, 1'b0, 64'h1234_5678_9ABC_DEF0, -64'sd5);
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstMid/flags", {60'b0, outValid1, inReady1, outValid4, inReady4}, 64'b0101);
        checkOutput("rstMid/result1", result1, 64'd0);
        checkOutput("rstMid/result4", result4, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        sawValid = 1'b0;
        repeat (80) begin @(posedge clk); #1; if (outValid1 || outValid4) sawValid = 1'b1; end
        checkOutput("rstMid/noValid", {63'b0, sawValid}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            rw  = 1'($urandom_range(0, 1));
            ra  = pickOperand();
            rb  = pickOperand();
            applyStimulus($sformatf("rnd%0d_op%0d_w%0d", i, rop, rw), rop, rw, ra, rb, refModel(rop, rw, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
